// File: rtl/reg_scoreboard_pkg.sv
// Shared register-file types: index widths, x0 constant and the per-instruction
// register access bundle used by decode, scoreboard and register file.
package reg_scoreboard_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_X0 = '0;

  typedef struct packed {
    reg_idx_t rs1;
    logic     rs1_en;
    reg_idx_t rs2;
    logic     rs2_en;
    reg_idx_t rd;
    logic     rd_we;
  } reg_access_t;

  // A source only matters if it is read and is not the hardwired zero register.
  function automatic logic src_live(input reg_idx_t idx, input logic en);
    return en && (idx != REG_X0);
  endfunction

  function automatic logic dst_tracked(input reg_idx_t rd, input logic we);
    return we && (rd != REG_X0);
  endfunction

  // One-hot over the writable registers only; x0 maps to all-zero.
  function automatic logic [NUM_REGS-1:1] reg_onehot(input reg_idx_t idx);
    logic [NUM_REGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v[NUM_REGS-1:1];
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode-side issue handshake, register-file read enables and writeback retire bus.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic     issue_valid;
  logic     issue_ready;
  reg_idx_t issue_rs1;
  reg_idx_t issue_rs2;
  logic     issue_rs1_en;
  logic     issue_rs2_en;
  reg_idx_t issue_rd;
  logic     issue_rd_we;
  logic     rf_rs1_en;
  logic     rf_rs2_en;
  logic     wb_valid;
  reg_idx_t wb_rd;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rs1_en, issue_rs2_en,
           issue_rd, issue_rd_we, wb_valid, wb_rd,
    input  issue_ready, rf_rs1_en, rf_rs2_en
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rs1_en, issue_rs2_en,
           issue_rd, issue_rd_we, wb_valid, wb_rd,
    output issue_ready, rf_rs1_en, rf_rs2_en
  );

endinterface

// File: rtl/reg_scoreboard_sb_hazard_check.sv
// Combinational RAW/WAW/capacity evaluation of one instruction against the busy set.
// Zero latency; the result feeds issue_ready directly.
module sb_hazard_check
  import reg_scoreboard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic [NUM_REGS-1:1] busy,
  input  logic [CNT_W-1:0]    count,
  input  reg_access_t         acc,
  output logic                tracked,
  output logic                raw,
  output logic                waw,
  output logic                full
);

  logic [NUM_REGS-1:0] busy_ext;

  assign busy_ext = {busy, 1'b0};

  always_comb begin
    tracked = dst_tracked(acc.rd, acc.rd_we);
    raw     = (src_live(acc.rs1, acc.rs1_en) && busy_ext[acc.rs1]) ||
              (src_live(acc.rs2, acc.rs2_en) && busy_ext[acc.rs2]);
    waw     = tracked && busy_ext[acc.rd];
    full    = tracked && (count == CNT_W'(MAX_OUTSTANDING));
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Issue scoreboard: stalls decode on RAW/WAW/too-many-outstanding, combinational ready;
// busy bits set/cleared one edge after issue/retire, no writeback bypass.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  sb,
  input  logic             flush,
  output logic             idle,
  output logic             err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_REGS-1:1] busy;
  logic [NUM_REGS-1:1] busy_nxt;
  logic [NUM_REGS-1:1] set_vec;
  logic [NUM_REGS-1:1] clr_vec;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_nxt;
  logic                err_nxt;

  reg_access_t acc;
  logic        tracked;
  logic        raw;
  logic        waw;
  logic        full;
  logic        ready;
  logic        fire;
  logic        alloc;
  logic        retire_hit;

  assign acc = '{rs1: sb.issue_rs1, rs1_en: sb.issue_rs1_en,
                 rs2: sb.issue_rs2, rs2_en: sb.issue_rs2_en,
                 rd:  sb.issue_rd,  rd_we:  sb.issue_rd_we};

  sb_hazard_check #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_hazard (
    .busy    (busy),
    .count   (count),
    .acc     (acc),
    .tracked (tracked),
    .raw     (raw),
    .waw     (waw),
    .full    (full)
  );

  always_comb begin
    ready      = !flush && !raw && !waw && !full;
    fire       = sb.issue_valid && ready;
    alloc      = fire && tracked;
    // reg_onehot drops x0, so a retire to x0 or to an idle register never hits.
    retire_hit = sb.wb_valid && (|(reg_onehot(sb.wb_rd) & busy));
  end

  assign sb.issue_ready = ready;
  assign sb.rf_rs1_en   = fire && sb.issue_rs1_en;
  assign sb.rf_rs2_en   = fire && sb.issue_rs2_en;
  assign idle           = (count == '0);

  always_comb begin
    set_vec   = alloc      ? reg_onehot(sb.issue_rd) : '0;
    clr_vec   = retire_hit ? reg_onehot(sb.wb_rd)    : '0;
    busy_nxt  = (busy & ~clr_vec) | set_vec;
    count_nxt = count;
    if (alloc && !retire_hit) begin
      count_nxt = count + CNT_W'(1);
    end else if (retire_hit && !alloc && (count != '0)) begin
      count_nxt = count - CNT_W'(1);
    end
    // Flush squashes tracking but the protocol-error record survives it.
    if (flush) begin
      busy_nxt  = '0;
      count_nxt = '0;
    end
    err_nxt = err || (sb.wb_valid && !retire_hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      busy  <= busy_nxt;
      count <= count_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed and randomized checks of reg_scoreboard against a register-level reference model.
module tb_reg_scoreboard;

  localparam int MAXO = 4;

  logic clk;
  logic rst;
  logic flush;
  logic idle;
  logic err;

  reg_scoreboard_if sif ();

  reg_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk   (clk),
    .rst   (rst),
    .sb    (sif),
    .flush (flush),
    .idle  (idle),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  bit busy_m [32];
  int cnt_m;
  bit err_m;

  function automatic bit exp_ready();
    bit trk;
    bit hz_raw;
    trk    = sif.issue_rd_we && (sif.issue_rd != 0);
    hz_raw = (sif.issue_rs1_en && sif.issue_rs1 != 0 && busy_m[sif.issue_rs1]) ||
             (sif.issue_rs2_en && sif.issue_rs2 != 0 && busy_m[sif.issue_rs2]);
    return !flush && !hz_raw && !(trk && busy_m[sif.issue_rd]) && !(trk && cnt_m == MAXO);
  endfunction

  task automatic model_clear(input bit with_err);
    for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
    cnt_m = 0;
    if (with_err) err_m = 1'b0;
  endtask

  task automatic model_edge();
    bit fire;
    bit trk;
    bit hit;
    fire = sif.issue_valid && exp_ready();
    trk  = sif.issue_rd_we && (sif.issue_rd != 0);
    hit  = sif.wb_valid && (sif.wb_rd != 0) && busy_m[sif.wb_rd];
    if (sif.wb_valid && !hit) err_m = 1'b1;
    if (flush) begin
      model_clear(1'b0);
    end else begin
      if (hit) begin
        busy_m[sif.wb_rd] = 1'b0;
        if (cnt_m > 0) cnt_m--;
      end
      if (fire && trk) begin
        busy_m[sif.issue_rd] = 1'b1;
        cnt_m++;
      end
    end
  endtask

  task automatic clear_inputs();
    sif.issue_valid  = 1'b0;
    sif.issue_rs1    = '0;
    sif.issue_rs2    = '0;
    sif.issue_rs1_en = 1'b0;
    sif.issue_rs2_en = 1'b0;
    sif.issue_rd     = '0;
    sif.issue_rd_we  = 1'b0;
    sif.wb_valid     = 1'b0;
    sif.wb_rd        = '0;
    flush            = 1'b0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    model_clear(1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (sif.issue_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", sif.issue_ready); end
    tick();
  endtask

  task automatic test_issue_basic();
    clear_inputs();
    sif.issue_valid = 1'b1; sif.issue_rd = 5'd5; sif.issue_rd_we = 1'b1;
    #2;
    checks++; if (sif.issue_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", sif.issue_ready); end
    checks++; if ({sif.rf_rs1_en, sif.rf_rs2_en} !== 2'b00) begin failures++; $display("FAIL basic_rf_en got=%b%b exp=00", sif.rf_rs1_en, sif.rf_rs2_en); end
    tick();
    clear_inputs();
    sif.issue_rs1 = 5'd5; sif.issue_rs1_en = 1'b1;
    #2;
    checks++; if (sif.issue_ready !== 1'b0) begin failures++; $display("FAIL basic_busy5 ready got=%b exp=0", sif.issue_ready); end
    checks++; if (idle !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", idle); end
    checks++; if (int'(dut.count) !== 1) begin failures++; $display("FAIL basic_count got=%0d exp=1", dut.count); end
  endtask

  task automatic test_raw_stall();
    sif.issue_valid = 1'b1;
    #2;
    checks++; if (sif.issue_ready !== 1'b0) begin failures++; $display("FAIL raw_stall got=%b exp=0", sif.issue_ready); end
    tick();
    sif.wb_valid = 1'b1; sif.wb_rd = 5'd5;
    #2;
    checks++; if (sif.issue_ready !== 1'b0) begin failures++; $display("FAIL raw_retire_cycle got=%b exp=0", sif.issue_ready); end
    checks++; if (sif.rf_rs1_en !== 1'b0) begin failures++; $display("FAIL raw_retire_rf got=%b exp=0", sif.rf_rs1_en); end
    tick();
    sif.wb_valid = 1'b0;
    #2;
    checks++; if (sif.issue_ready !== 1'b1) begin failures++; $display("FAIL raw_after_retire got=%b exp=1", sif.issue_ready); end
    checks++; if (sif.rf_rs1_en !== 1'b1) begin failures++; $display("FAIL raw_after_rf got=%b exp=1", sif.rf_rs1_en); end
    tick();
    clear_inputs();
    #2;
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL raw_idle got=%b exp=1", idle); end
  endtask

  task automatic test_full();
    int drain [4] = '{1, 3, 4, 6};
    for (int i = 1; i <= 4; i++) begin
      clear_inputs();
      sif.issue_valid = 1'b1; sif.issue_rd = 5'(i); sif.issue_rd_we = 1'b1;
      #2;
      checks++; if (sif.issue_ready !== 1'b1) begin failures++; $display("FAIL full_fill%0d got=%b exp=1", i, sif.issue_ready); end
      tick();
    end
    clear_inputs();
    sif.issue_valid = 1'b1; sif.issue_rd = 5'd6; sif.issue_rd_we = 1'b1;
    #2;
    checks++; if (sif.issue_ready !== 1'b0) begin failures++; $display("FAIL full_fifth got=%b exp=0", sif.issue_ready); end
    sif.wb_valid = 1'b1; sif.wb_rd = 5'd2;
    #1;
    checks++; if (sif.issue_ready !== 1'b0) begin failures++; $display("FAIL full_with_retire got=%b exp=0", sif.issue_ready); end
    tick();
    sif.wb_valid = 1'b0;
    #2;
    checks++; if (sif.issue_ready !== 1'b1) begin failures++; $display("FAIL full_next got=%b exp=1", sif.issue_ready); end
    tick();
    clear_inputs();
    #2;
    checks++; if (int'(dut.count) !== 4) begin failures++; $display("FAIL full_count got=%0d exp=4", dut.count); end
    for (int k = 0; k < 4; k++) begin
      clear_inputs();
      sif.wb_valid = 1'b1; sif.wb_rd = 5'(drain[k]);
      tick();
    end
    clear_inputs();
    #2;
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL full_drain_idle got=%b exp=1", idle); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL full_drain_err got=%b exp=0", err); end
  endtask

  task automatic test_x0();
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      sif.issue_valid = 1'b1; sif.issue_rd = 5'd0; sif.issue_rd_we = 1'b1;
      sif.issue_rs1 = 5'd0; sif.issue_rs1_en = 1'b1;
      #2;
      checks++; if (sif.issue_ready !== 1'b1) begin failures++; $display("FAIL x0_ready%0d got=%b exp=1", i, sif.issue_ready); end
      checks++; if (sif.rf_rs1_en !== 1'b1) begin failures++; $display("FAIL x0_rf%0d got=%b exp=1", i, sif.rf_rs1_en); end
      tick();
    end
    clear_inputs();
    #2;
    checks++; if (int'(dut.count) !== 0) begin failures++; $display("FAIL x0_count got=%0d exp=0", dut.count); end
  endtask

  task automatic test_flush();
    int probe [4] = '{1, 2, 3, 9};
    for (int i = 1; i <= 3; i++) begin
      clear_inputs();
      sif.issue_valid = 1'b1; sif.issue_rd = 5'(i); sif.issue_rd_we = 1'b1;
      tick();
    end
    clear_inputs();
    sif.issue_valid = 1'b1; sif.issue_rd = 5'd9; sif.issue_rd_we = 1'b1; flush = 1'b1;
    #2;
    checks++; if (sif.issue_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", sif.issue_ready); end
    tick();
    clear_inputs();
    #2;
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL flush_idle got=%b exp=1", idle); end
    checks++; if (int'(dut.count) !== 0) begin failures++; $display("FAIL flush_count got=%0d exp=0", dut.count); end
    for (int k = 0; k < 4; k++) begin
      sif.issue_rs1 = 5'(probe[k]); sif.issue_rs1_en = 1'b1;
      #1;
      checks++; if (sif.issue_ready !== 1'b1) begin failures++; $display("FAIL flush_busy_x%0d got=%b exp=1", probe[k], sif.issue_ready); end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    bit e;
    int r;
    int n;
    for (int cyc = 0; cyc < 400; cyc++) begin
      clear_inputs();
      sif.issue_valid  = 1'($urandom_range(0, 1));
      sif.issue_rs1    = 5'($urandom_range(0, 7));
      sif.issue_rs2    = 5'($urandom_range(0, 7));
      sif.issue_rs1_en = 1'($urandom_range(0, 1));
      sif.issue_rs2_en = 1'($urandom_range(0, 1));
      sif.issue_rd     = 5'($urandom_range(0, 7));
      sif.issue_rd_we  = ($urandom_range(0, 3) != 0);
      r = $urandom_range(1, 7);
      n = $urandom_range(0, 99);
      if (n < 45 && busy_m[r]) begin
        sif.wb_valid = 1'b1; sif.wb_rd = 5'(r);
      end else if (n == 99) begin
        sif.wb_valid = 1'b1; sif.wb_rd = 5'($urandom_range(0, 31));
      end
      flush = ($urandom_range(0, 39) == 0);
      #2;
      e = exp_ready();
      checks++; if (sif.issue_ready !== e) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, sif.issue_ready, e); end
      checks++; if (sif.rf_rs1_en !== (sif.issue_valid && e && sif.issue_rs1_en)) begin failures++; $display("FAIL rand_rf1 cyc=%0d got=%b", cyc, sif.rf_rs1_en); end
      checks++; if (sif.rf_rs2_en !== (sif.issue_valid && e && sif.issue_rs2_en)) begin failures++; $display("FAIL rand_rf2 cyc=%0d got=%b", cyc, sif.rf_rs2_en); end
      checks++; if (int'(dut.count) !== cnt_m) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, dut.count, cnt_m); end
      checks++; if (idle !== (cnt_m == 0)) begin failures++; $display("FAIL rand_idle cyc=%0d got=%b exp=%b", cyc, idle, cnt_m == 0); end
      checks++; if (err !== err_m) begin failures++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", cyc, err, err_m); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_err_async_reset();
    test_reset();
    clear_inputs();
    sif.wb_valid = 1'b1; sif.wb_rd = 5'd7;
    tick();
    clear_inputs();
    #2;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err); end
    tick();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err); end
    sif.issue_valid = 1'b1; sif.issue_rd = 5'd3; sif.issue_rd_we = 1'b1;
    tick();
    clear_inputs();
    sif.issue_rs1 = 5'd3; sif.issue_rs1_en = 1'b1;
    #1;
    checks++; if (sif.issue_ready !== 1'b0) begin failures++; $display("FAIL pre_rst_busy got=%b exp=0", sif.issue_ready); end
    rst = 1'b1;
    #1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL arst_err got=%b exp=0", err); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL arst_idle got=%b exp=1", idle); end
    checks++; if (sif.issue_ready !== 1'b1) begin failures++; $display("FAIL arst_busy got=%b exp=1", sif.issue_ready); end
    model_clear(1'b1);
    clear_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
    sif.wb_valid = 1'b1; sif.wb_rd = 5'd3;
    tick();
    clear_inputs();
    #2;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL stale_retire_err got=%b exp=1", err); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_issue_basic();
    test_raw_stall();
    test_full();
    test_x0();
    test_flush();
    test_random();
    test_err_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
